conv_encoder_k3: RTL

- Rate-1/2 feed-forward convolutional encoder. Transmit-side counterpart of the decoder's branch-metric / ACS chain.
- Accepts one information bit per handshake and emits one 2-bit code symbol (pair) per bit.
- On frame end, automatically appends K-1 zero tail bits so the trellis terminates in state 0, which the decoder's traceback relies on.
- Sits between the bit source and the channel model in the encode–channel–decode test path.

---
 rtl/viterbi_pkg.sv | 17 +
 rtl/conv_parity.sv | 13 +
 rtl/conv_encoder_k3.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared encode/decode definitions for the K-constraint Viterbi path.
// Code-pair bit ordering here must match the branch-metric units.
package viterbi_pkg;

    localparam int K_DEF = 3;
    localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
    localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

    // [1] = G0 parity, [0] = G1 parity
    typedef logic [1:0] code_pair_t;

    typedef enum logic {
        RUN,
        FLUSH
    } enc_state_t;

endpackage

// File: rtl/conv_parity.sv
// One generator tap: XOR of the tap vector masked by the polynomial.
// The MSB of taps is the bit currently being encoded.
module conv_parity #(
    parameter int K = 3,
    parameter logic [K-1:0] G = '1
) (
    input  logic [K-1:0] taps,
    output logic         parity
);

    assign parity = ^(taps & G);

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2 feed-forward convolutional encoder with automatic
// zero-tail termination so every frame ends in trellis state 0.
module conv_encoder_k3
    import viterbi_pkg::*;
#(
    parameter int K = K_DEF,
    parameter logic [K-1:0] G0 = K'(G0_DEF),
    parameter logic [K-1:0] G1 = K'(G1_DEF)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output code_pair_t out_pair,
    output logic       out_last,
    output logic       busy
);

    localparam int CW = $clog2(K);
    localparam logic [CW-1:0] TAIL = CW'(K - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    enc_state_t state;
    enc_state_t state_nxt;
    logic [CW-1:0] tail_cnt;
    logic [CW-1:0] tail_nxt;

    logic [K-2:0] sr;
    logic [K-1:0] v;

    code_pair_t pair_q;
    code_pair_t pair_d;
    logic valid_q;
    logic last_q;
    logic busy_q;

    logic adv;
    logic ready;
    logic produce;
    logic take;
    logic b;
    logic last_sym;
    logic accept_last;

    // The output slot is free when empty or being drained this cycle.
    assign adv = !valid_q || out_ready;
    assign take = in_valid && ready;
    assign accept_last = valid_q && out_ready && last_q;

    assign v = {b, sr};

    conv_parity #(
        .K(K),
        .G(G0)
    ) u_par0 (
        .taps  (v),
        .parity(pair_d[1])
    );

    conv_parity #(
        .K(K),
        .G(G1)
    ) u_par1 (
        .taps  (v),
        .parity(pair_d[0])
    );

    // Next state, tail counter and which bit feeds the taps.
    always_comb begin
        state_nxt = state;
        tail_nxt  = tail_cnt;
        ready     = 1'b0;
        produce   = 1'b0;
        b         = 1'b0;
        last_sym  = 1'b0;
        unique case (state)
            RUN: begin
                ready = adv;
                if (in_valid && adv) begin
                    produce = 1'b1;
                    b       = in_bit;
                    if (in_last) begin
                        state_nxt = FLUSH;
                        tail_nxt  = TAIL;
                    end
                end
            end
            FLUSH: begin
                if (adv) begin
                    produce  = 1'b1;
                    tail_nxt = tail_cnt - ONE;
                    if (tail_cnt == ONE) begin
                        last_sym  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // FSM state and tail counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            tail_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tail_cnt <= tail_nxt;
        end
    end

    // Shift register and single-stage output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            pair_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (produce) begin
            sr      <= v[K-1:1];
            pair_q  <= pair_d;
            valid_q <= 1'b1;
            last_q  <= last_sym;
        end else if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    // Frame activity: a new frame's first bit wins over the
    // previous frame's final tail being accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
        end else if (take) begin
            busy_q <= 1'b1;
        end else if (accept_last) begin
            busy_q <= 1'b0;
        end
    end

    // Outputs are forced idle while reset is held.
    assign in_ready  = ready && !rst;
    assign out_valid = valid_q && !rst;
    assign out_last  = last_q && valid_q && !rst;
    assign out_pair  = rst ? 2'b00 : pair_q;
    assign busy      = busy_q && !rst;

endmodule
